emmc_blk_buf: RTL and testbench

- Sits directly upstream of the eMMC transaction state machine, between the user stream side and the eMMC byte interface (we/start/blk_cnt/dat_i/dat_o/dvalid/ready).
- Accepts block-transfer requests over a valid/ready handshake.
- Buffers write data in a TX FIFO and issues start only once the first 512-byte block is resident.
- Captures read bytes into an RX FIFO drained by the user. Reports completion and sticky underrun/overflow errors.

---
 rtl/emmc_blk_buf_if.sv | 23 ++
 rtl/emmc_blk_buf.sv | 169 ++++++++++++++++
 tb/tb_emmc_blk_buf.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/emmc_blk_buf_if.sv
// Byte-level link between emmc_blk_buf (master) and the eMMC transaction state machine (slave).
// Signal names follow the buffer's view of the link.
interface emmc_blk_buf_if #(
  parameter int BLK_CNT_WIDTH = 16
);
  logic                     sm_we_o;
  logic                     sm_start_o;
  logic [BLK_CNT_WIDTH-1:0] sm_blk_cnt_o;
  logic [7:0]               sm_dat_o;
  logic [7:0]               sm_dat_i;
  logic                     sm_dvalid_i;
  logic                     sm_ready_i;

  modport master (
    output sm_we_o, sm_start_o, sm_blk_cnt_o, sm_dat_o,
    input  sm_dat_i, sm_dvalid_i, sm_ready_i
  );

  modport slave (
    input  sm_we_o, sm_start_o, sm_blk_cnt_o, sm_dat_o,
    output sm_dat_i, sm_dvalid_i, sm_ready_i
  );
endinterface

// File: rtl/emmc_blk_buf.sv
// Block buffer in front of the eMMC SM: TX/RX byte FIFOs, prefill gating, sticky error flags.
// Optional macro EMMC_BLK_BUF_STATS_EN adds the blk_done_cnt_o completed-block counter.
module emmc_blk_buf #(
  parameter int BLK_CNT_WIDTH = 16,
  parameter int FIFO_DEPTH    = 1024,
  parameter int BLK_BYTES     = 512
) (
  input  logic                     clk_i,
  input  logic                     arst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [BLK_CNT_WIDTH-1:0] req_blk_cnt_i,
  output logic                     done_o,
  output logic                     err_underrun_o,
  output logic                     err_overflow_o,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic [7:0]               wr_data_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [7:0]               rd_data_o,
`ifdef EMMC_BLK_BUF_STATS_EN
  output logic [31:0]              blk_done_cnt_o,
`endif
  emmc_blk_buf_if.master           sm
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = BLK_CNT_WIDTH + 9;

  typedef enum logic [2:0] {IDLE, PREFILL, START, BUSY, DONE} state_e;

  state_e                   state_q, state_d;
  logic                     we_q, seen_busy_q, err_un_q, err_ov_q;
  logic [BLK_CNT_WIDTH-1:0] blk_cnt_q;
  logic [RW-1:0]            rem_q, prefill_thr;
  logic [7:0]               tx_mem [FIFO_DEPTH];
  logic [7:0]               rx_mem [FIFO_DEPTH];
  logic [AW-1:0]            tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [CW-1:0]            tx_cnt_q, rx_cnt_q;
  logic                     tx_full, tx_empty, rx_full, rx_empty;
  logic                     tx_push, tx_pop, rx_push, rx_pop;
  logic                     hs, byte_evt, prefill_ok;

  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  // Bytes from the SM only count while the transaction is running.
  assign byte_evt = (state_q == BUSY) & sm.sm_dvalid_i;
  assign tx_push  = wr_valid_i & ~tx_full;
  assign tx_pop   = byte_evt & we_q & ~tx_empty;
  assign rx_push  = byte_evt & ~we_q & ~rx_full;
  assign rx_pop   = rd_ready_i & ~rx_empty;
  assign hs       = req_valid_i & req_ready_o;

  assign prefill_thr = (rem_q >= RW'(BLK_BYTES)) ? RW'(BLK_BYTES) : rem_q;
  assign prefill_ok  = (RW'(tx_cnt_q) >= prefill_thr);

  assign wr_ready_o      = ~tx_full;
  assign rd_valid_o      = ~rx_empty;
  assign rd_data_o       = rx_empty ? 8'h00 : rx_mem[rx_rp_q];
  assign sm.sm_dat_o     = tx_empty ? 8'h00 : tx_mem[tx_rp_q];
  assign sm.sm_we_o      = we_q;
  assign sm.sm_blk_cnt_o = blk_cnt_q;
  assign err_underrun_o  = err_un_q;
  assign err_overflow_o  = err_ov_q;

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wp_q] <= wr_data_i;
    if (rx_push) rx_mem[rx_wp_q] <= sm.sm_dat_i;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
      if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + CW'(1);
        2'b01:   tx_cnt_q <= tx_cnt_q - CW'(1);
        default: tx_cnt_q <= tx_cnt_q;
      endcase
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + CW'(1);
        2'b01:   rx_cnt_q <= rx_cnt_q - CW'(1);
        default: rx_cnt_q <= rx_cnt_q;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    req_ready_o   = 1'b0;
    sm.sm_start_o = 1'b0;
    done_o        = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = sm.sm_ready_i;
        if (req_valid_i && sm.sm_ready_i) begin
          if (req_blk_cnt_i == '0) state_d = DONE;
          else if (req_we_i)       state_d = PREFILL;
          else                     state_d = START;
        end
      end
      PREFILL: if (prefill_ok) state_d = START;
      START: begin
        sm.sm_start_o = 1'b1;
        state_d       = BUSY;
      end
      // The SM must be seen busy before its ready can mean completion.
      BUSY: if (seen_busy_q && sm.sm_ready_i) state_d = DONE;
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      blk_cnt_q   <= '0;
      rem_q       <= '0;
      seen_busy_q <= 1'b0;
      err_un_q    <= 1'b0;
      err_ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == START)                      seen_busy_q <= 1'b0;
      else if (state_q == BUSY && !sm.sm_ready_i) seen_busy_q <= 1'b1;
      if (hs) begin
        we_q      <= req_we_i;
        blk_cnt_q <= req_blk_cnt_i;
        rem_q     <= RW'(req_blk_cnt_i) * RW'(BLK_BYTES);
        err_un_q  <= 1'b0;
        err_ov_q  <= 1'b0;
      end else if (byte_evt) begin
        if (rem_q != '0)          rem_q    <= rem_q - RW'(1);
        if (we_q && tx_empty)     err_un_q <= 1'b1;
        if (!we_q && rx_full)     err_ov_q <= 1'b1;
      end
    end
  end

`ifdef EMMC_BLK_BUF_STATS_EN
  // A block completes when remaining steps down onto a block boundary.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      blk_done_cnt_o <= '0;
    end else if (byte_evt && !hs && rem_q != '0 &&
                 (rem_q % RW'(BLK_BYTES)) == RW'(1)) begin
      blk_done_cnt_o <= blk_done_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_emmc_blk_buf.sv
// Directed bench for emmc_blk_buf with a small eMMC SM model driving the byte link.
module tb_emmc_blk_buf;
  localparam int BCW = 16;

  logic           clk_i = 1'b0;
  logic           arst_ni;
  logic           req_valid_i, req_we_i;
  logic [BCW-1:0] req_blk_cnt_i;
  logic           req_ready_o, done_o, err_underrun_o, err_overflow_o;
  logic           wr_valid_i, wr_ready_o, rd_valid_o, rd_ready_i;
  logic [7:0]     wr_data_i, rd_data_o;
`ifdef EMMC_BLK_BUF_STATS_EN
  logic [31:0]    blk_done_cnt;
`endif

  emmc_blk_buf_if #(.BLK_CNT_WIDTH(BCW)) sm_if ();

  emmc_blk_buf #(.BLK_CNT_WIDTH(BCW), .FIFO_DEPTH(1024), .BLK_BYTES(512)) dut (
    .clk_i          (clk_i),
    .arst_ni        (arst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_blk_cnt_i  (req_blk_cnt_i),
    .done_o         (done_o),
    .err_underrun_o (err_underrun_o),
    .err_overflow_o (err_overflow_o),
    .wr_valid_i     (wr_valid_i),
    .wr_ready_o     (wr_ready_o),
    .wr_data_i      (wr_data_i),
    .rd_valid_o     (rd_valid_o),
    .rd_ready_i     (rd_ready_i),
    .rd_data_o      (rd_data_o),
`ifdef EMMC_BLK_BUF_STATS_EN
    .blk_done_cnt_o (blk_done_cnt),
`endif
    .sm             (sm_if.master)
  );

  always #5 clk_i = ~clk_i;

  int         errors = 0;
  int         checks = 0;
  int         start_seen = 0;
  int         done_seen = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_exp[$];

  always @(negedge clk_i) begin
    if (sm_if.sm_start_o) start_seen++;
    if (done_o) done_seen++;
    if (rd_valid_o && rd_ready_i) rx_q.push_back(rd_data_o);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [7:0] rd_pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic push_bytes(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      wr_valid_i = 1'b1;
      wr_data_i  = 8'(base + i);
      while (!wr_ready_o && w < 50) begin tick; w++; end
      if (w >= 50) check_eq("push_timeout", 32'(w), 0);
      tick;
      tx_exp.push_back(8'(base + i));
    end
    wr_valid_i = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [BCW-1:0] cnt);
    int w = 0;
    req_valid_i = 1'b1;
    req_we_i = we;
    req_blk_cnt_i = cnt;
    while (!req_ready_o && w < 100) begin tick; w++; end
    if (w >= 100) check_eq("req_timeout", 32'(w), 0);
    tick;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_start(output int cyc);
    cyc = 0;
    while (!sm_if.sm_start_o && cyc < 3000) begin tick; cyc++; end
    if (cyc >= 3000) check_eq("start_timeout", 32'(cyc), 0);
  endtask

  // Entered in BUSY; flag_at names the byte number at which the direction's error must first show.
  task automatic sm_run(input logic we, input int n, input int flag_at, output int bad);
    int w = 0;
    bad = 0;
    sm_if.sm_ready_i = 1'b0;
    tick;
    for (int i = 0; i < n; i++) begin
      if (we) begin
        if (tx_exp.size() > 0) begin
          if (sm_if.sm_dat_o !== tx_exp[0]) bad++;
          void'(tx_exp.pop_front());
        end
      end else begin
        sm_if.sm_dat_i = rd_pat(i);
      end
      sm_if.sm_dvalid_i = 1'b1;
      tick;
      sm_if.sm_dvalid_i = 1'b0;
      if (flag_at > 0 && i + 1 == flag_at - 1)
        check_eq("err_before", we ? 32'(err_underrun_o) : 32'(err_overflow_o), 0);
      if (flag_at > 0 && i + 1 == flag_at)
        check_eq("err_at", we ? 32'(err_underrun_o) : 32'(err_overflow_o), 1);
    end
    sm_if.sm_ready_i = 1'b1;
    while (!done_o && w < 20) begin tick; w++; end
    if (w >= 20) check_eq("done_timeout", 32'(w), 0);
    tick;
  endtask

  initial begin
    int cyc, bad, s0, d0, base, mism;
    arst_ni = 1'b0;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_blk_cnt_i = '0;
    wr_valid_i = 1'b0; wr_data_i = '0; rd_ready_i = 1'b0;
    sm_if.sm_dat_i = '0; sm_if.sm_dvalid_i = 1'b0; sm_if.sm_ready_i = 1'b1;
    tick; tick;
    check_eq("rst_wr_ready", 32'(wr_ready_o), 1);
    check_eq("rst_rd_valid", 32'(rd_valid_o), 0);
    check_eq("rst_done", 32'(done_o), 0);
    check_eq("rst_start", 32'(sm_if.sm_start_o), 0);
    check_eq("rst_sm_dat", 32'(sm_if.sm_dat_o), 0);
    check_eq("rst_errs", {30'd0, err_underrun_o, err_overflow_o}, 0);
    arst_ni = 1'b1;
    tick;

    // Single-block write with the block fully resident beforehand
    push_bytes(512, 0);
    s0 = start_seen; d0 = done_seen;
    do_req(1'b1, 16'd1);
    check_eq("wr1_we", 32'(sm_if.sm_we_o), 1);
    wait_start(cyc);
    check_eq("wr1_start_lat", 32'(cyc), 1);
    tick;
    check_eq("wr1_start_1cyc", 32'(sm_if.sm_start_o), 0);
    check_eq("wr1_blk_cnt", 32'(sm_if.sm_blk_cnt_o), 1);
    sm_run(1'b1, 512, 0, bad);
    check_eq("wr1_data_bad", 32'(bad), 0);
    check_eq("wr1_starts", 32'(start_seen - s0), 1);
    check_eq("wr1_dones", 32'(done_seen - d0), 1);
    check_eq("wr1_underrun", 32'(err_underrun_o), 0);

    // Prefill gating: start waits for a full block
    push_bytes(300, 0);
    s0 = start_seen;
    do_req(1'b1, 16'd2);
    repeat (10) tick;
    check_eq("pf_no_start", 32'(start_seen - s0), 0);
    push_bytes(212, 300);
    check_eq("pf_start_early", 32'(sm_if.sm_start_o), 0);
    tick;
    check_eq("pf_start_now", 32'(sm_if.sm_start_o), 1);
    tick;
    check_eq("pf_start_1cyc", 32'(sm_if.sm_start_o), 0);
    push_bytes(512, 512);
    sm_run(1'b1, 1024, 0, bad);
    check_eq("pf_data_bad", 32'(bad), 0);
    check_eq("pf_underrun", 32'(err_underrun_o), 0);

    // Underrun: only 700 of 1024 bytes supplied
    push_bytes(512, 0);
    do_req(1'b1, 16'd2);
    wait_start(cyc);
    tick;
    push_bytes(188, 512);
    sm_run(1'b1, 1024, 701, bad);
    check_eq("ur_data_bad", 32'(bad), 0);
    check_eq("ur_sticky", 32'(err_underrun_o), 1);

    // Multi-block read with continuous draining
    rd_ready_i = 1'b1;
    base = rx_q.size();
    d0 = done_seen;
    do_req(1'b0, 16'd3);
    check_eq("rd_ur_cleared", 32'(err_underrun_o), 0);
    check_eq("rd_we", 32'(sm_if.sm_we_o), 0);
    wait_start(cyc);
    check_eq("rd_start_lat", 32'(cyc), 0);
    tick;
    sm_run(1'b0, 1536, 0, bad);
    repeat (5) tick;
    mism = 0;
    for (int i = 0; i < 1536 && base + i < rx_q.size(); i++)
      if (rx_q[base + i] !== rd_pat(i)) mism++;
    check_eq("rd_count", 32'(rx_q.size() - base), 1536);
    check_eq("rd_data_bad", 32'(mism), 0);
    check_eq("rd_dones", 32'(done_seen - d0), 1);
    check_eq("rd_overflow", 32'(err_overflow_o), 0);

    // Overflow: nobody drains, 1536 bytes into a 1024-byte FIFO
    rd_ready_i = 1'b0;
    base = rx_q.size();
    do_req(1'b0, 16'd3);
    wait_start(cyc);
    tick;
    sm_run(1'b0, 1536, 1025, bad);
    check_eq("ov_sticky", 32'(err_overflow_o), 1);
    rd_ready_i = 1'b1;
    repeat (1040) tick;
    rd_ready_i = 1'b0;
    mism = 0;
    for (int i = 0; i < 1024 && base + i < rx_q.size(); i++)
      if (rx_q[base + i] !== rd_pat(i)) mism++;
    check_eq("ov_held", 32'(rx_q.size() - base), 1024);
    check_eq("ov_data_bad", 32'(mism), 0);

    // Reset during BUSY, then a zero-block request
    push_bytes(5, 8'h41);
    do_req(1'b0, 16'd1);
    wait_start(cyc);
    tick;
    sm_if.sm_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sm_if.sm_dat_i = rd_pat(i);
      sm_if.sm_dvalid_i = 1'b1;
      tick;
    end
    sm_if.sm_dvalid_i = 1'b0;
    check_eq("mr_rdv_pre", 32'(rd_valid_o), 1);
    #2 arst_ni = 1'b0;
    #1;
    tx_exp.delete();
    check_eq("mr_rd_valid", 32'(rd_valid_o), 0);
    check_eq("mr_rd_data", 32'(rd_data_o), 0);
    check_eq("mr_sm_dat", 32'(sm_if.sm_dat_o), 0);
    check_eq("mr_wr_ready", 32'(wr_ready_o), 1);
    check_eq("mr_blk_cnt", 32'(sm_if.sm_blk_cnt_o), 0);
    check_eq("mr_start_done", {30'd0, sm_if.sm_start_o, done_o}, 0);
    sm_if.sm_ready_i = 1'b1;
    tick; tick;
    arst_ni = 1'b1;
    tick;
    s0 = start_seen; d0 = done_seen;
    do_req(1'b1, 16'd0);
    cyc = 1;
    while (!done_o && cyc < 5) begin tick; cyc++; end
    check_eq("zb_done_lat_ok", 32'(cyc <= 2), 1);
    repeat (4) tick;
    check_eq("zb_dones", 32'(done_seen - d0), 1);
    check_eq("zb_no_start", 32'(start_seen - s0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
